fm_discriminator: RTL and testbench

- Sits directly downstream of the CORDIC magnitude/angle stage and consumes its AXI-Stream output: tdata[31:0] is magnitude, tdata[63:32] is angle.
- Computes the wrapped phase difference between consecutive samples, which is the FM discriminator output.
- Applies a magnitude squelch, then decimates by 2^C_LOG2_DECIMATION using accumulate-and-dump averaging.
- Emits one 32-bit signed audio sample per block to the downstream audio/FIFO stage.

---
 rtl/fm_demod_pkg.sv | 28 ++
 rtl/fm_discriminator_phase_delta.sv | 73 +++++++
 rtl/fm_discriminator.sv | 122 ++++++++++++
 tb/tb_fm_discriminator.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_demod_pkg.sv
// Shared types and constants for the FM demodulator chain.
//   angle_t      : signed 32-bit phase, full circle = 2^32
//   mag_t        : unsigned 32-bit magnitude
//   disc_state_t : discriminator priming state
//   MAG_LSB / ANGLE_LSB : field offsets inside the CORDIC output beat
package fm_demod_pkg;

  localparam longint unsigned ANGLE_FULL_SCALE = 64'h0000_0001_0000_0000;
  localparam int ANGLE_W   = $clog2(ANGLE_FULL_SCALE);
  localparam int MAG_W     = 32;
  localparam int MAG_LSB   = 0;
  localparam int ANGLE_LSB = 32;

  typedef logic signed [ANGLE_W-1:0] angle_t;
  typedef logic        [MAG_W-1:0]   mag_t;

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } disc_state_t;

  // Phase difference taken modulo the full circle; the signed result is the
  // shortest rotation, so crossing +/-pi needs no special handling.
  function automatic angle_t wrap_delta(input angle_t cur, input angle_t prev);
    return cur - prev;
  endfunction

endpackage

// File: rtl/fm_discriminator_phase_delta.sv
// Per-beat phase differentiator with magnitude squelch.
//   clk, reset   : clock, synchronous active-high reset
//   beat_accept  : an input beat is consumed this cycle
//   angle, mag   : fields of the current beat
//   thresh       : squelch threshold (0 disables)
//   delta        : wrapped phase delta of the current beat (0 when priming/squelched)
//   squelch      : current beat is below the threshold
module fm_discriminator_phase_delta
  import fm_demod_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   beat_accept,
  input  angle_t angle,
  input  mag_t   mag,
  input  mag_t   thresh,
  output angle_t delta,
  output logic   squelch
);

  disc_state_t state_r;
  disc_state_t state_next_s;
  angle_t      prev_angle_r;
  angle_t      raw_delta_s;

  // State register and previous-angle history
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= PRIME;
      prev_angle_r <= {ANGLE_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (beat_accept) begin
        // squelched beats still advance the history so the next delta is clean
        prev_angle_r <= angle;
      end else begin
        prev_angle_r <= prev_angle_r;
      end
    end
  end

  // Next-state and delta/squelch decode
  always_comb begin
    state_next_s = state_r;
    raw_delta_s  = {ANGLE_W{1'b0}};
    squelch      = (mag < thresh);
    case (state_r)
      PRIME: begin
        // first beat has no predecessor: contributes zero delta
        raw_delta_s = {ANGLE_W{1'b0}};
        if (beat_accept) begin
          state_next_s = RUN;
        end else begin
          state_next_s = PRIME;
        end
      end
      RUN: begin
        raw_delta_s  = wrap_delta(angle, prev_angle_r);
        state_next_s = RUN;
      end
      default: begin
        raw_delta_s  = {ANGLE_W{1'b0}};
        state_next_s = PRIME;
      end
    endcase
    if (squelch) begin
      delta = {ANGLE_W{1'b0}};
    end else begin
      delta = raw_delta_s;
    end
  end

endmodule

// File: rtl/fm_discriminator.sv
// FM discriminator: phase differentiation, squelch and accumulate-and-dump
// decimation by 2^C_LOG2_DECIMATION of the CORDIC magnitude/angle stream.
//   s00_axis_* : input stream, tdata[31:0] magnitude, tdata[63:32] angle
//   m00_axis_* : output stream, one signed averaged phase delta per block
//   squelch_thresh : unsigned magnitude threshold (0 disables)
//   squelch_active : squelch decision of the most recent accepted beat
module fm_discriminator
  import fm_demod_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_LOG2_DECIMATION      = 3
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                s00_axis_tvalid,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  input  logic [31:0]                         squelch_thresh,
  output logic                                squelch_active
);

  localparam int L  = C_LOG2_DECIMATION;
  localparam int D  = 1 << L;
  localparam int AW = ANGLE_W + L;
  localparam int CW = (L > 0) ? L : 1;

  logic                 beat_accept_s;
  logic                 last_beat_s;
  angle_t               angle_s;
  mag_t                 mag_s;
  angle_t               delta_s;
  logic                 squelch_s;
  logic signed [AW-1:0] acc_r;
  logic signed [AW-1:0] delta_ext_s;
  logic signed [AW-1:0] acc_sum_s;
  logic signed [AW-1:0] acc_avg_s;
  logic [CW-1:0]        cnt_r;
  logic                 tlast_flag_r;
  logic                 unused_bits_s;

  assign angle_s = angle_t'(s00_axis_tdata[ANGLE_LSB +: ANGLE_W]);
  assign mag_s   = s00_axis_tdata[MAG_LSB +: MAG_W];

  // Stall the input only while a produced sample is waiting downstream
  assign s00_axis_tready = ~(m00_axis_tvalid & ~m00_axis_tready);
  assign beat_accept_s   = s00_axis_tvalid & s00_axis_tready;
  assign last_beat_s     = (cnt_r == CW'(D - 1));

  assign delta_ext_s = AW'(delta_s);
  assign acc_sum_s   = acc_r + delta_ext_s;
  assign acc_avg_s   = acc_sum_s >>> L;

  assign m00_axis_tstrb = {(C_M00_AXIS_TDATA_WIDTH/8){1'b1}};
  assign unused_bits_s  = ^{s00_axis_tstrb, acc_avg_s};

  fm_discriminator_phase_delta u_phase_delta (
    .clk         (s00_axis_aclk),
    .reset       (s00_axis_areset),
    .beat_accept (beat_accept_s),
    .angle       (angle_s),
    .mag         (mag_s),
    .thresh      (squelch_thresh),
    .delta       (delta_s),
    .squelch     (squelch_s)
  );

  // Block accumulator, beat counter, tlast flag and squelch status
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      acc_r          <= {AW{1'b0}};
      cnt_r          <= {CW{1'b0}};
      tlast_flag_r   <= 1'b0;
      squelch_active <= 1'b0;
    end else if (beat_accept_s) begin
      squelch_active <= squelch_s;
      if (last_beat_s) begin
        acc_r        <= {AW{1'b0}};
        cnt_r        <= {CW{1'b0}};
        tlast_flag_r <= 1'b0;
      end else begin
        acc_r        <= acc_sum_s;
        cnt_r        <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        tlast_flag_r <= tlast_flag_r | s00_axis_tlast;
      end
    end else begin
      acc_r          <= acc_r;
      cnt_r          <= cnt_r;
      tlast_flag_r   <= tlast_flag_r;
      squelch_active <= squelch_active;
    end
  end

  // Output register: a dump reloads it even while the old sample is leaving
  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= {C_M00_AXIS_TDATA_WIDTH{1'b0}};
    end else if (beat_accept_s && last_beat_s) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tlast  <= tlast_flag_r | s00_axis_tlast;
      m00_axis_tdata  <= acc_avg_s[C_M00_AXIS_TDATA_WIDTH-1:0];
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tdata  <= m00_axis_tdata;
    end else begin
      m00_axis_tvalid <= m00_axis_tvalid;
      m00_axis_tlast  <= m00_axis_tlast;
      m00_axis_tdata  <= m00_axis_tdata;
    end
  end

endmodule

// File: tb/tb_fm_discriminator.sv
module tb_fm_discriminator;

  logic        clk = 1'b0;
  logic        areset = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic [63:0] s_tdata = 64'd0;
  logic [7:0]  s_tstrb = 8'hFF;
  logic [31:0] thresh = 32'd0;
  logic        m_tready = 1'b1;
  logic        m_tready1 = 1'b1;

  logic        s_tready0, m_tvalid0, m_tlast0, sq0;
  logic [31:0] m_tdata0;
  logic [3:0]  m_tstrb0;
  logic        s_tready1, m_tvalid1, m_tlast1, sq1;
  logic [31:0] m_tdata1;
  logic [3:0]  m_tstrb1;

  always #5 clk = ~clk;

  fm_discriminator #(.C_LOG2_DECIMATION(3)) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(areset),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
    .s00_axis_tready(s_tready0), .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid0), .m00_axis_tlast(m_tlast0),
    .m00_axis_tdata(m_tdata0), .m00_axis_tstrb(m_tstrb0),
    .squelch_thresh(thresh), .squelch_active(sq0)
  );

  fm_discriminator #(.C_LOG2_DECIMATION(0)) dut1 (
    .s00_axis_aclk(clk), .s00_axis_areset(areset),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
    .s00_axis_tready(s_tready1), .m00_axis_tready(m_tready1),
    .m00_axis_tvalid(m_tvalid1), .m00_axis_tlast(m_tlast1),
    .m00_axis_tdata(m_tdata1), .m00_axis_tstrb(m_tstrb1),
    .squelch_thresh(thresh), .squelch_active(sq1)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: per instance, expected outputs {tlast, data}
  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic [31:0] m_prev[2];
  bit          m_primed[2];
  longint      m_acc[2];
  int          m_cnt[2];
  bit          m_tl[2];
  bit          m_sq[2];
  int          lg[2];

  bit          hs0, hs1;
  logic [31:0] cur;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_prev[k] = 32'd0; m_primed[k] = 1'b0; m_acc[k] = 64'sd0;
      m_cnt[k] = 0; m_tl[k] = 1'b0; m_sq[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // One accepted beat: wrapped delta, squelch, running sum, dump every 2^lg beats
  task automatic model_beat(input int k, input logic [31:0] ang, input logic [31:0] mag,
                            input logic [31:0] thr, input bit last, output bit dumped);
    int          d;
    bit          sq;
    longint      avg;
    logic [31:0] a32;
    logic [31:0] diff;
    sq = (mag < thr);
    diff = ang - m_prev[k];
    d = m_primed[k] ? int'(diff) : 0;
    if (sq) d = 0;
    m_sq[k] = sq;
    m_primed[k] = 1'b1;
    m_prev[k] = ang;
    m_acc[k] = m_acc[k] + longint'(d);
    m_cnt[k] = m_cnt[k] + 1;
    m_tl[k] = m_tl[k] | last;
    dumped = 1'b0;
    if (m_cnt[k] == (1 << lg[k])) begin
      avg = m_acc[k] >>> lg[k];
      a32 = avg[31:0];
      if (k == 0) q0.push_back({m_tl[k], a32});
      else        q1.push_back({m_tl[k], a32});
      m_acc[k] = 64'sd0; m_cnt[k] = 0; m_tl[k] = 1'b0;
      dumped = 1'b1;
    end
  endtask

  task automatic cycle(input bit v, input logic [31:0] ang, input logic [31:0] mag,
                       input bit last, input bit rdy);
    bit d0, d1, ohs0, ohs1;
    @(negedge clk);
    s_tvalid = v; s_tdata = {ang, mag}; s_tlast = last; m_tready = rdy;
    #1;
    chk("out_valid0", 64'(m_tvalid0), 64'(q0.size() != 0));
    chk("out_valid1", 64'(m_tvalid1), 64'(q1.size() != 0));
    chk("in_ready0", 64'(s_tready0), 64'(!(q0.size() != 0 && !rdy)));
    if (q0.size() != 0) chk("out_data0", 64'({m_tlast0, m_tdata0}), 64'(q0[0]));
    if (q1.size() != 0) chk("out_data1", 64'({m_tlast1, m_tdata1}), 64'(q1[0]));
    hs0 = v && s_tready0;
    hs1 = v && s_tready1;
    ohs0 = m_tvalid0 && rdy;
    ohs1 = m_tvalid1 && m_tready1;
    if (ohs0 && q0.size() != 0) void'(q0.pop_front());
    if (ohs1 && q1.size() != 0) void'(q1.pop_front());
    @(posedge clk);
    #1;
    if (hs0) begin
      model_beat(0, ang, mag, thresh, last, d0);
      chk("squelch0", 64'(sq0), 64'(m_sq[0]));
      if (d0) chk("latency0", 64'({m_tvalid0, m_tlast0, m_tdata0}), 64'({1'b1, q0[q0.size()-1]}));
    end
    if (hs1) begin
      model_beat(1, ang, mag, thresh, last, d1);
      chk("squelch1", 64'(sq1), 64'(m_sq[1]));
      if (d1) chk("latency1", 64'({m_tvalid1, m_tlast1, m_tdata1}), 64'({1'b1, q1[q1.size()-1]}));
    end
  endtask

  task automatic run(input int n, input logic [31:0] step, input logic [31:0] mag, input int tl_at);
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, cur, mag, (i == tl_at), 1'b1);
      cur = cur + step;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    areset = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 64'(m_tvalid0), 64'd0);
    chk("rst_last", 64'(m_tlast0), 64'd0);
    chk("rst_data", 64'(m_tdata0), 64'd0);
    chk("rst_squelch", 64'(sq0), 64'd0);
    chk("rst_ready", 64'(s_tready0), 64'd1);
    chk("rst_valid1", 64'(m_tvalid1), 64'd0);
    chk("tstrb", 64'(m_tstrb0), 64'hF);
  endtask

  initial begin
    int          n;
    int          bound;
    bit          pend;
    bit          rv, rl, rr;
    logic [31:0] ra, rm, st;

    lg[0] = 3;
    lg[1] = 0;
    model_reset();

    // 1: constant angle -> zero average
    do_reset();
    cur = 32'h1000_0000;
    run(8, 32'd0, 32'd100, -1);
    chk("t1_valid", 64'(m_tvalid0), 64'd1);
    chk("t1_data", 64'(m_tdata0), 64'h0000_0000);
    chk("t1_last", 64'(m_tlast0), 64'd0);

    // 2: ramp, first block carries the primed zero delta
    do_reset();
    cur = 32'h0;
    run(8, 32'h0100_0000, 32'd100, -1);
    chk("t2_blk1", 64'(m_tdata0), 64'h00E0_0000);
    chk("t2_d1_valid", 64'(m_tvalid1), 64'd1);
    chk("t2_d1_data", 64'(m_tdata1), 64'h0100_0000);
    run(8, 32'h0100_0000, 32'd100, -1);
    chk("t2_blk2", 64'(m_tdata0), 64'h0100_0000);

    // 3: wrap-around both ways
    do_reset();
    cur = 32'h6000_0000;
    run(8, 32'h2000_0000, 32'd100, -1);
    run(8, 32'h2000_0000, 32'd100, -1);
    chk("t3_wrap_a", 64'(m_tdata0), 64'h2000_0000);
    run(8, 32'h2000_0000, 32'd100, -1);
    chk("t3_wrap_b", 64'(m_tdata0), 64'h2000_0000);
    cur = cur - 32'h4000_0000;
    run(8, 32'hE000_0000, 32'd100, -1);
    chk("t3_neg", 64'(m_tdata0), 64'hE000_0000);

    // 4: squelch, including mag == thresh (not squelched)
    do_reset();
    thresh = 32'd1000;
    cur = 32'h0;
    run(8, 32'h0100_0000, 32'd500, -1);
    chk("t4_sq_data", 64'(m_tdata0), 64'd0);
    chk("t4_sq_on", 64'(sq0), 64'd1);
    run(1, 32'h0100_0000, 32'd2000, -1);
    chk("t4_sq_off", 64'(sq0), 64'd0);
    run(1, 32'h0100_0000, 32'd1000, -1);
    chk("t4_sq_equal", 64'(sq0), 64'd0);
    run(6, 32'h0100_0000, 32'd2000, -1);
    chk("t4_blk", 64'(m_tdata0), 64'h0100_0000);
    thresh = 32'd0;

    // 5: backpressure
    do_reset();
    cur = 32'h0;
    run(8, 32'h0100_0000, 32'd100, -1);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, cur, 32'd100, 1'b0, 1'b0);
      chk("t5_rdy_low", 64'(s_tready0), 64'd0);
      chk("t5_hold", 64'(m_tdata0), 64'h00E0_0000);
    end
    n = 0;
    bound = 0;
    while (n < 8 && bound < 50) begin
      cycle(1'b1, cur, 32'd100, 1'b0, 1'b1);
      if (hs0) begin
        cur = cur + 32'h0100_0000;
        n++;
      end
      bound++;
    end
    chk("t5_count", 64'(n), 64'd8);
    chk("t5_blk2", 64'(m_tdata0), 64'h0100_0000);

    // 6: tlast scoping and mid-block reset
    do_reset();
    cur = 32'h0;
    run(8, 32'h0100_0000, 32'd100, 4);
    chk("t6_last1", 64'(m_tlast0), 64'd1);
    run(8, 32'h0100_0000, 32'd100, -1);
    chk("t6_last0", 64'(m_tlast0), 64'd0);
    run(4, 32'h0100_0000, 32'd100, -1);
    do_reset();
    run(7, 32'h0100_0000, 32'd100, -1);
    chk("t6_no_out", 64'(m_tvalid0), 64'd0);
    run(1, 32'h0100_0000, 32'd100, -1);
    chk("t6_out_valid", 64'(m_tvalid0), 64'd1);
    chk("t6_out_data", 64'(m_tdata0), 64'h00E0_0000);

    // Randomized traffic against the model
    do_reset();
    cur = 32'h0;
    pend = 1'b0;
    rv = 1'b0; rl = 1'b0; ra = 32'd0; rm = 32'd0;
    for (int c = 0; c < 600; c++) begin
      if (c % 64 == 0) thresh = $urandom_range(1500, 0);
      if (!pend) begin
        rv = ($urandom_range(3, 0) != 0);
        if ($urandom_range(3, 0) == 0) begin
          ra = $urandom;
        end else begin
          st = $urandom_range(32'h0400_0000, 0);
          ra = cur + st - 32'h0200_0000;
        end
        rm = $urandom_range(2000, 0);
        rl = ($urandom_range(7, 0) == 0);
      end
      rr = ($urandom_range(3, 0) != 0);
      cycle(rv, ra, rm, rl, rr);
      if (hs0) cur = ra;
      pend = rv && !hs0;
    end
    thresh = 32'd0;
    for (int i = 0; i < 4; i++) cycle(1'b0, cur, 32'd0, 1'b0, 1'b1);
    chk("drain0", 64'(q0.size()), 64'd0);
    chk("drain1", 64'(q1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
